// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default parameters for the CPU clock controller.
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {MANUAL = 2'd0, AUTO = 2'd1, HALTED = 2'd2} clk_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_AUTO_DIV        = 4;
endpackage

// File: rtl/input_debounce.sv
// Synchronizer chain plus stable-count debouncer for one asynchronous pad input.
module input_debounce import cpu_ctrl_pkg::*; #(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic [CW-1:0]          cnt;
  logic                   sync_out;

  assign sync_out = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= {SYNC_STAGES{RESET_VAL}};
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], raw};
  end

  // Any cycle of agreement restarts the count, so short glitches never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clean <= RESET_VAL;
    end else if (sync_out == clean) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      clean <= sync_out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// Operator-input conditioner producing the single-cycle CPU clock enable
// in manual (per press) or auto (divided) mode, with a sticky halt.
module cpu_clock_ctrl import cpu_ctrl_pkg::*; #(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int AUTO_DIV        = DEF_AUTO_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_btn_n,
  input  logic mode_sw,
  input  logic halt,
  output logic cpu_clk_en,
  output logic auto_mode,
  output logic halted,
  output logic step_led
);
  localparam int DW = $clog2(AUTO_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

  clk_state_t    state;
  logic [DW-1:0] div;
  logic          step_clean, mode_clean;
  logic          step_prev, mode_prev;
  logic          press, mode_rise, mode_fall;

  input_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)
  ) u_step_db (
    .clk(clk), .rst_n(rst_n), .raw(step_btn_n), .clean(step_clean)
  );

  input_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)
  ) u_mode_db (
    .clk(clk), .rst_n(rst_n), .raw(mode_sw), .clean(mode_clean)
  );

  assign press     = step_prev & ~step_clean;
  assign mode_rise = mode_clean & ~mode_prev;
  assign mode_fall = ~mode_clean & mode_prev;

  assign auto_mode = mode_clean;
  assign step_led  = ~step_clean;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prev <= 1'b1;
      mode_prev <= 1'b0;
    end else begin
      step_prev <= step_clean;
      mode_prev <= mode_clean;
    end
  end

  // Enable is registered: it fires the cycle after a press or a divider wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MANUAL;
      div        <= '0;
      cpu_clk_en <= 1'b0;
    end else begin
      cpu_clk_en <= 1'b0;
      if (halt) begin
        state <= HALTED;
      end else begin
        case (state)
          MANUAL: begin
            if (mode_rise) begin
              state <= AUTO;
              div   <= '0;
            end else begin
              cpu_clk_en <= press;
            end
          end
          AUTO: begin
            if (mode_fall) begin
              state <= MANUAL;
              div   <= '0;
            end else begin
              div        <= (div == DIV_LAST) ? '0 : div + 1'b1;
              cpu_clk_en <= (div == DIV_LAST);
            end
          end
          default: state <= HALTED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, AUTO_DIV=4.
module tb_cpu_clock_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_btn_n = 1'b1;
  logic mode_sw = 1'b0;
  logic halt = 1'b0;
  logic cpu_clk_en, auto_mode, halted, step_led;

  int total = 0;
  int bad = 0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  cpu_clock_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .AUTO_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .step_btn_n(step_btn_n), .mode_sw(mode_sw), .halt(halt),
    .cpu_clk_en(cpu_clk_en), .auto_mode(auto_mode), .halted(halted), .step_led(step_led)
  );

  typedef struct {
    logic step_n;
    logic mode;
    int   cycles;
    int   pulses;
    logic led;
    logic auto_m;
    logic hlt_o;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_clk_en && n < max);
    if (!cpu_clk_en) n = -1;
  endtask

  task automatic run_row(input int i);
    int p;
    p = 0;
    step_btn_n = tbl[i].step_n;
    mode_sw    = tbl[i].mode;
    for (int c = 0; c < tbl[i].cycles; c++) begin
      tick();
      if (cpu_clk_en) p++;
    end
    chk($sformatf("row%0d pulses", i), p, tbl[i].pulses);
    chk($sformatf("row%0d step_led", i), int'(step_led), int'(tbl[i].led));
    chk($sformatf("row%0d auto_mode", i), int'(auto_mode), int'(tbl[i].auto_m));
    chk($sformatf("row%0d halted", i), int'(halted), int'(tbl[i].hlt_o));
  endtask

  // The enable must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (cpu_clk_en && prev_en) begin
        bad++;
        $display("FAIL en_double: got 1 want 0");
      end
    end
    prev_en = cpu_clk_en;
  end

  initial begin
    int n;
    int p;
    //            step mode cyc pul led auto halt
    tbl[0]  = '{1'b1, 1'b0, 20, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 10, 1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0,  3, 0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0,  2, 0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0,  3, 0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 20, 3, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 12, 3, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1,  8, 2, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 40, 0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 10, 0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 10, 0, 1'b0, 1'b0, 1'b1};

    repeat (3) tick();
    chk("rst cpu_clk_en", int'(cpu_clk_en), 0);
    chk("rst auto_mode", int'(auto_mode), 0);
    chk("rst halted", int'(halted), 0);
    chk("rst step_led", int'(step_led), 0);
    rst_n = 1'b1;

    for (int i = 0; i <= 6; i++) run_row(i);

    // Exact press latency: 2 sync + 4 debounce + 1 edge-detect register.
    step_btn_n = 1'b0;
    wait_pulse(20, n);
    chk("press latency", n, 7);
    tick();
    chk("pulse width", int'(cpu_clk_en), 0);
    p = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (cpu_clk_en) p++; end
    chk("held press pulses", p, 0);
    step_btn_n = 1'b1;
    p = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (cpu_clk_en) p++; end
    chk("release pulses", p, 0);

    for (int i = 7; i <= 9; i++) run_row(i);

    // Halt asserted in the cycle just before the next auto pulse is due.
    wait_pulse(8, n);
    chk("auto pulse found", int'(n > 0), 1);
    repeat (3) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt suppresses pulse", int'(cpu_clk_en), 0);
    chk("halt entered", int'(halted), 1);

    for (int i = 10; i <= 12; i++) run_row(i);

    // Async reset while halted, then restart with the switch already in auto.
    rst_n = 1'b0;
    #1;
    chk("rst halted drop", int'(halted), 0);
    chk("rst en drop", int'(cpu_clk_en), 0);
    mode_sw = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    p = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (cpu_clk_en) p++; end
    chk("post-rst manual pulses", p, 0);
    chk("post-rst auto_mode early", int'(auto_mode), 0);
    tick();
    chk("post-rst auto_mode", int'(auto_mode), 1);
    wait_pulse(10, n);
    chk("post-rst first auto pulse", n, 5);

    // Reset while the enable is high drops it without waiting for an edge.
    if (cpu_clk_en) begin
      rst_n = 1'b0;
      #1;
      chk("rst mid-pulse", int'(cpu_clk_en), 0);
    end
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    p = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (cpu_clk_en) p++; end
    chk("no owed pulse", p, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
